nodf_module_intf: RTL and testbench
===================================

Name: nodf_module_intf

Overview:
Passive observer for the ap_ctrl handshake (ap_start/ap_ready/ap_done/ap_continue) of one non-dataflow HLS module.
- Tracks transaction state.
- Counts starts and completions.
- Measures per-transaction latency (last/min/max) and total run cycles.
- Freezes all statistics once the testbench-level finish signal is seen.
- Sits beside the DUT top; drives nothing back into it.

Parameters:
CNT_W, 32, width of start/done/cycle counters (saturating)
LAT_W, 32, width of latency registers (saturating)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
ap_start  in  1  observed module start request
ap_ready  in  1  observed module ready (input accepted)
ap_done  in  1  observed module done
ap_continue  in  1  observed continue; tie 1 when module has none
finish  in  1  end-of-simulation/run indication
state  out  2  0=IDLE, 1=BUSY, 2=DONE_WAIT, 3=FINISHED
busy  out  1  high when state is BUSY or DONE_WAIT
start_pulse  out  1  one-cycle pulse in each start-event cycle (registered, visible next cycle)
done_pulse  out  1  one-cycle pulse in each completion cycle (registered, visible next cycle)
start_cnt  out  CNT_W  number of start events
done_cnt  out  CNT_W  number of completions
cycle_cnt  out  CNT_W  cycles since reset release, stops at finish
last_lat  out  LAT_W  latency of most recent completed transaction
min_lat  out  LAT_W  minimum completed latency
max_lat  out  LAT_W  maximum completed latency

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE.
  - All counters, last_lat, max_lat and the pulses = 0.
  - min_lat = all ones.
- All updates occur on the rising edge of clock. Outputs are registered.
- Start event:
  - state IDLE and ap_start=1; or
  - back-to-back: state BUSY/DONE_WAIT, completion this cycle and ap_start=1 and ap_ready=1.
- Completion:
  - state BUSY/DONE_WAIT, ap_done=1 and ap_continue=1.
- Transitions:
  - IDLE -> BUSY on a start event.
  - BUSY -> DONE_WAIT when ap_done=1 and ap_continue=0.
  - BUSY/DONE_WAIT -> IDLE on completion without a back-to-back start.
  - BUSY/DONE_WAIT -> BUSY on completion with a back-to-back start.
  - DONE_WAIT holds while ap_continue=0.
- Zero-cycle transaction: ap_start=1 and ap_done=1 and ap_continue=1 in IDLE counts as a start and a completion in the same cycle, with latency 0. State stays IDLE.
- Latency:
  - An internal counter clears on a start event and increments each BUSY/DONE_WAIT cycle.
  - On completion, latency = number of cycles from the start-event cycle to the completion cycle. Start in cycle t, done in t+N gives N.
  - On completion: last_lat=lat, min_lat=min(min_lat,lat), max_lat=max(max_lat,lat).
- All counters saturate at all-ones; no wrap.
- ap_done while IDLE without ap_start: ignored, no count.
- Finish:
  - The first cycle with finish=1 moves state to FINISHED (sticky until reset).
  - In FINISHED, no counter or statistic changes; pulses held 0.
  - An event in the same cycle as finish is still counted.
- Reset mid-transaction: everything returns to reset values immediately; a partial transaction is discarded.

Optional Feature:
Macro NODF_STALL_CNT_EN.
- Defined: adds output stall_cnt (CNT_W). It counts cycles with state BUSY/DONE_WAIT, ap_done=1 and ap_continue=0 (output back-pressure). It resets to 0, saturates, and freezes in FINISHED.
- Undefined: no port and no logic.

Decomposition:
- Shared package nodf_mon_pkg holds:
  - state enum type (IDLE/BUSY/DONE_WAIT/FINISHED, 2-bit).
  - CNT_W/LAT_W default constants.
  - LAT_INIT_MIN all-ones constant.
- One natural sub-module: nodf_sat_counter, a parameterised-width saturating counter with clear and enable. It is reused for start_cnt, done_cnt, cycle_cnt, latency and stall_cnt.

Test Plan:
- Reset check: hold reset=0, toggle inputs -> state=0, all counts 0, min_lat=all ones, max_lat=0.
- Single transaction: ap_start=1 at cycle 2, ap_done=1 with ap_continue=1 at cycle 7 -> start_cnt=1, done_cnt=1, last_lat=min_lat=max_lat=5, state back to IDLE.
- Three transactions with latencies 3, 8, 4, the second back-to-back with the first (start and ready in the done cycle) -> done_cnt=3, last_lat=4, min_lat=3, max_lat=8, no IDLE cycle between txn1 and txn2.
- Back-pressure: ap_done=1 with ap_continue=0 for 4 cycles, then continue=1 -> state DONE_WAIT for 4 cycles, done_cnt increments once, stall_cnt=4 (when enabled).
- Finish: assert finish mid-run after 2 completions, then drive 2 more transactions -> state=3, done_cnt stays 2, cycle_cnt frozen.
- Async reset during BUSY: drop reset between clock edges -> outputs clear immediately, before the next edge. Next start gives start_cnt=1.

Source files
------------

// File: rtl/nodf_mon_pkg.sv
// Shared types and defaults for the ap_ctrl handshake observer.
package nodf_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_DONE_WAIT = 2'd2,
        ST_FINISHED  = 2'd3
    } state_t;

    localparam int CNT_W_DEF = 32;
    localparam int LAT_W_DEF = 32;
    localparam logic [LAT_W_DEF-1:0] LAT_INIT_MIN = '1;

endpackage

// File: rtl/nodf_sat_counter.sv
// Saturating up-counter. A clear cycle that is also enabled loads 1, so the
// clearing cycle itself is counted.
module nodf_sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= W'(en);
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nodf_module_intf.sv
// Passive ap_ctrl observer: transaction state, start/done counts, latency stats.
// Optional NODF_STALL_CNT_EN adds stall_cnt (done held off by ap_continue=0).
module nodf_module_intf
    import nodf_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic             busy,
    output logic             start_pulse,
    output logic             done_pulse,
    output logic [CNT_W-1:0] start_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [LAT_W-1:0] last_lat,
    output logic [LAT_W-1:0] min_lat,
    output logic [LAT_W-1:0] max_lat
`ifdef NODF_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    state_t st, st_nxt;
    logic active, idle, run, comp, start_ev;
    logic [LAT_W-1:0] lat_cnt, lat;

    // In FINISHED neither active nor idle holds, so every event below is
    // suppressed and all counters freeze without extra gating.
    assign active   = (st == ST_BUSY) || (st == ST_DONE_WAIT);
    assign idle     = (st == ST_IDLE);
    assign run      = (st != ST_FINISHED);
    assign comp     = ap_done && ap_continue && (active || (idle && ap_start));
    assign start_ev = (idle && ap_start) || (active && comp && ap_start && ap_ready);
    assign lat      = active ? lat_cnt : '0;

    assign state = st;
    assign busy  = active;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) st <= ST_IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE: begin
                if (start_ev && !comp) st_nxt = ST_BUSY;
            end
            ST_BUSY, ST_DONE_WAIT: begin
                if (comp)         st_nxt = start_ev ? ST_BUSY : ST_IDLE;
                else if (ap_done) st_nxt = ST_DONE_WAIT;
            end
            default: ;
        endcase
        if (finish) st_nxt = ST_FINISHED;
    end

    nodf_sat_counter #(.W(CNT_W)) u_start_cnt (
        .clock(clock), .reset(reset), .clr(1'b0), .en(start_ev), .cnt(start_cnt));
    nodf_sat_counter #(.W(CNT_W)) u_done_cnt (
        .clock(clock), .reset(reset), .clr(1'b0), .en(comp), .cnt(done_cnt));
    nodf_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock(clock), .reset(reset), .clr(1'b0), .en(run), .cnt(cycle_cnt));
    // Holds N during the cycle that is N cycles after the start event.
    nodf_sat_counter #(.W(LAT_W)) u_lat_cnt (
        .clock(clock), .reset(reset), .clr(start_ev), .en(start_ev || active),
        .cnt(lat_cnt));

`ifdef NODF_STALL_CNT_EN
    nodf_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock(clock), .reset(reset), .clr(1'b0),
        .en(active && ap_done && !ap_continue), .cnt(stall_cnt));
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_pulse <= 1'b0;
            done_pulse  <= 1'b0;
            last_lat    <= '0;
            min_lat     <= '1;
            max_lat     <= '0;
        end else begin
            start_pulse <= start_ev;
            done_pulse  <= comp;
            if (comp) begin
                last_lat <= lat;
                if (lat < min_lat) min_lat <= lat;
                if (lat > max_lat) max_lat <= lat;
            end
        end
    end

endmodule

// File: tb/tb_nodf_module_intf.sv
// Bench for nodf_module_intf: timestamp-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_nodf_module_intf;

    localparam int CNT_W = 32;
    localparam int LAT_W = 32;
    localparam longint unsigned SAT = 64'hFFFF_FFFF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b1, finish = 1'b0;
    logic [1:0]       state;
    logic             busy, start_pulse, done_pulse;
    logic [CNT_W-1:0] start_cnt, done_cnt, cycle_cnt;
    logic [LAT_W-1:0] last_lat, min_lat, max_lat;
`ifdef NODF_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    nodf_module_intf #(.CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .state(state), .busy(busy), .start_pulse(start_pulse), .done_pulse(done_pulse),
        .start_cnt(start_cnt), .done_cnt(done_cnt), .cycle_cnt(cycle_cnt),
        .last_lat(last_lat), .min_lat(min_lat), .max_lat(max_lat)
`ifdef NODF_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is remembered by its start timestamp.
    int              m_st;
    bit              m_sp, m_dp;
    longint unsigned m_sc, m_dc, m_cyc, m_last, m_min, m_max, m_stall, m_time, m_t0;

    function automatic longint unsigned inc(input longint unsigned v);
        return (v >= SAT) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_sp = 0; m_dp = 0;
        m_sc = 0; m_dc = 0; m_cyc = 0; m_last = 0; m_min = SAT; m_max = 0;
        m_stall = 0; m_time = 0; m_t0 = 0;
    endtask

    task automatic model_step();
        bit in_txn, is_idle, dv, sv;
        longint unsigned lat;
        if (m_st == 3) begin
            m_sp = 0; m_dp = 0;
        end else begin
            in_txn  = (m_st == 1) || (m_st == 2);
            is_idle = (m_st == 0);
            dv = ap_done && ap_continue && (in_txn || (is_idle && ap_start));
            sv = (is_idle && ap_start) || (in_txn && dv && ap_start && ap_ready);
            m_cyc = inc(m_cyc);
            if (dv) begin
                lat = in_txn ? (m_time - m_t0) : 0;
                m_dc = inc(m_dc);
                m_last = lat;
                if (lat < m_min) m_min = lat;
                if (lat > m_max) m_max = lat;
            end
            if (sv) begin
                m_t0 = m_time;
                m_sc = inc(m_sc);
            end
            if (in_txn && ap_done && !ap_continue) m_stall = inc(m_stall);
            if (in_txn) m_st = dv ? (sv ? 1 : 0) : (ap_done ? 2 : m_st);
            else        m_st = (sv && !dv) ? 1 : 0;
            m_sp = sv; m_dp = dv;
            if (finish) m_st = 3;
        end
        m_time++;
    endtask

    always @(posedge clock) begin
        if (reset) model_step();
        #1;
        if (cmp_en) begin
            chk("state", state, m_st);
            chk("busy", busy, (m_st == 1 || m_st == 2));
            chk("start_pulse", start_pulse, m_sp);
            chk("done_pulse", done_pulse, m_dp);
            chk("start_cnt", start_cnt, m_sc);
            chk("done_cnt", done_cnt, m_dc);
            chk("cycle_cnt", cycle_cnt, m_cyc);
            chk("last_lat", last_lat, m_last);
            chk("min_lat", min_lat, m_min);
            chk("max_lat", max_lat, m_max);
`ifdef NODF_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, m_stall);
`endif
        end
    end

    task automatic drive(input bit s, input bit r, input bit d, input bit c, input bit f);
        @(negedge clock);
        ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 1, 0);
    endtask

    task automatic rand_in(input bit f);
        @(negedge clock);
        ap_start    = ($urandom_range(0, 99) < 40);
        ap_ready    = ($urandom_range(0, 99) < 70);
        ap_done     = ($urandom_range(0, 99) < 35);
        ap_continue = ($urandom_range(0, 99) < 70);
        finish      = f;
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        model_reset();
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_start_cnt", start_cnt, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_min_lat", min_lat, SAT);
        chk("rst_max_lat", max_lat, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    int dw;

    initial begin
        // Reset held with inputs toggling.
        #3 reset = 1'b0;
        model_reset();
        cmp_en = 1'b1;
        repeat (4) rand_in(1'($urandom_range(0, 1)));
        @(negedge clock);
        chk("hold_state", state, 0);
        chk("hold_cycle_cnt", cycle_cnt, 0);
        chk("hold_min_lat", min_lat, SAT);
        chk("hold_busy", busy, 0);
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
        reset = 1'b1;

        // Single transaction: start in cycle 2, done in cycle 7.
        drive(1, 0, 0, 1, 0);
        idle(4);
        drive(0, 0, 1, 1, 0);
        idle(1);
        chk("t1_start_cnt", start_cnt, 1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_last_lat", last_lat, 5);
        chk("t1_min_lat", min_lat, 5);
        chk("t1_max_lat", max_lat, 5);
        chk("t1_state", state, 0);

        // Latencies 3 (back-to-back into next), 8, 4.
        do_reset();
        drive(1, 0, 0, 1, 0);
        idle(2);
        drive(1, 1, 1, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk("t3_b2b_state", state, 1);
        idle(6);
        drive(0, 0, 1, 1, 0);
        idle(1);
        drive(1, 0, 0, 1, 0);
        idle(3);
        drive(0, 0, 1, 1, 0);
        idle(1);
        chk("t3_done_cnt", done_cnt, 3);
        chk("t3_last_lat", last_lat, 4);
        chk("t3_min_lat", min_lat, 3);
        chk("t3_max_lat", max_lat, 8);
        chk("t3_state", state, 0);

        // Back-pressure: done held off for 4 cycles.
        do_reset();
        drive(1, 0, 0, 1, 0);
        idle(2);
        dw = 0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, (i == 4), 0);
            if (state == 2'd2) dw++;
        end
        idle(1);
        if (state == 2'd2) dw++;
        chk("bp_dw_cycles", dw, 4);
        chk("bp_done_cnt", done_cnt, 1);
        chk("bp_state", state, 0);
`ifdef NODF_STALL_CNT_EN
        chk("bp_stall_cnt", stall_cnt, 4);
`endif

        // Finish after two completions freezes everything.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 1, 0);
            idle(2);
            drive(0, 0, 1, 1, 0);
        end
        drive(0, 0, 0, 1, 1);
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 1, 0);
            idle(2);
            drive(0, 0, 1, 1, 0);
        end
        idle(1);
        chk("fin_state", state, 3);
        chk("fin_done_cnt", done_cnt, 2);
        chk("fin_start_cnt", start_cnt, 2);
        chk("fin_cycle_cnt", cycle_cnt, 10);
        chk("fin_done_pulse", done_pulse, 0);

        // Reset while BUSY discards the partial transaction.
        do_reset();
        drive(1, 0, 0, 1, 0);
        idle(2);
        chk("mid_busy", state, 1);
        do_reset();
        drive(1, 0, 0, 1, 0);
        idle(1);
        chk("mid_restart_cnt", start_cnt, 1);
        chk("mid_restart_state", state, 1);

        // Zero-cycle transaction from IDLE.
        do_reset();
        drive(1, 0, 1, 1, 0);
        idle(1);
        chk("z_start_cnt", start_cnt, 1);
        chk("z_done_cnt", done_cnt, 1);
        chk("z_last_lat", last_lat, 0);
        chk("z_state", state, 0);

        // Randomized episodes, some with a finish and a mid-run reset.
        for (int ep = 0; ep < 6; ep++) begin
            int fin_at;
            do_reset();
            fin_at = (ep % 2 == 1) ? int'($urandom_range(100, 500)) : -1;
            for (int i = 0; i < 600; i++) begin
                rand_in(i == fin_at);
                if (ep == 4 && i == 300) do_reset();
            end
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
